// File: rtl/ftdi_tx_mass_ctrl_pkg.sv
// Shared types and helpers for the FTDI TX mass-transfer sequencer.
package ftdi_mass_pkg;

    localparam int unsigned HDR_BYTES = 4;
    localparam int unsigned TX_BYTES  = 4;
    localparam int unsigned REM_W     = 33;

    typedef enum logic {
        HDR  = 1'b0,
        SEND = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] tdata;
        logic [3:0]  tkeep;
        logic        tlast;
    } tx_word_t;

    // Lane mask for a word that starts with 'rem' bytes still owed to the host.
    function automatic logic [3:0] keep_from_remaining(input logic [REM_W-1:0] rem);
        if (rem >= REM_W'(TX_BYTES)) return 4'hF;
        case (rem[1:0])
            2'd3:    return 4'h7;
            2'd2:    return 4'h3;
            2'd1:    return 4'h1;
            default: return 4'h0;
        endcase
    endfunction

endpackage

// File: rtl/ftdi_tx_mass_ctrl_if.sv
// RX header stream and TX data stream of the mass-transfer sequencer.
// master: the sequencer side; slave: the host-facing FIFO side.
interface ftdi_tx_mass_ctrl_if;
    logic        rx_tvalid;
    logic [7:0]  rx_tdata;
    logic        rx_tready;
    logic        tx_tready;
    logic        tx_tvalid;
    logic [31:0] tx_tdata;
    logic [3:0]  tx_tkeep;
    logic        tx_tlast;

    modport master (
        input  rx_tvalid, rx_tdata, tx_tready,
        output rx_tready, tx_tvalid, tx_tdata, tx_tkeep, tx_tlast
    );

    modport slave (
        output rx_tvalid, rx_tdata, tx_tready,
        input  rx_tready, tx_tvalid, tx_tdata, tx_tkeep, tx_tlast
    );
endinterface

// File: rtl/ftdi_tx_mass_ctrl_hdr_collect.sv
// Assembles the 4-byte little-endian length header from the RX byte stream.
// Optional idle timeout on a partial header when TX_MASS_TIMEOUT_EN is defined.
module ftdi_hdr_collect
    import ftdi_mass_pkg::*;
#(
    parameter int unsigned LEN_W       = 32,
    parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             rx_tvalid,
    input  logic [7:0]       rx_tdata,
    output logic             len_valid,
    output logic [LEN_W-1:0] len
);

    logic [1:0]  idx_q;
    logic [23:0] low_q;
    logic [31:0] hdr_c;
    logic        beat;
    logic        drop;

    if (TIMEOUT_CYC < 2) begin : g_timeout_chk
        $error("TIMEOUT_CYC must be at least 2");
    end

    assign beat      = arm & rx_tvalid;
    assign len_valid = beat && (idx_q == 2'(HDR_BYTES - 1));
    // The final byte is forwarded directly so the sequencer can react in the same cycle.
    assign hdr_c     = {rx_tdata, low_q};
    assign len       = hdr_c[LEN_W-1:0];

`ifdef TX_MASS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0] idle_q;

    assign drop = (idx_q != 2'd0) && !beat && (idle_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || beat || (idx_q == 2'd0) || drop) idle_q <= '0;
        else                                        idle_q <= idle_q + CNT_W'(1);
    end
`else
    assign drop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            low_q <= '0;
        end else if (beat) begin
            case (idx_q)
                2'd0:    low_q[7:0]   <= rx_tdata;
                2'd1:    low_q[15:8]  <= rx_tdata;
                2'd2:    low_q[23:16] <= rx_tdata;
                default: ;
            endcase
            idx_q <= idx_q + 2'd1;
        end else if (drop) begin
            idx_q <= '0;
        end
    end

endmodule

// File: rtl/ftdi_tx_mass_ctrl.sv
// Reads a length header from RX, then streams that many incrementing pattern bytes on TX.
// Build option: TX_MASS_TIMEOUT_EN enables the partial-header idle timeout.
module ftdi_tx_mass_ctrl
    import ftdi_mass_pkg::*;
#(
    parameter int unsigned LEN_W       = 32,
    parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
    input  logic                clk,
    input  logic                rst,
    ftdi_tx_mass_ctrl_if.master bus,
    output logic                busy,
    output logic                done
);

    localparam int unsigned CW = LEN_W + 1;

    if (LEN_W < 1 || LEN_W > 32) begin : g_len_chk
        $error("LEN_W must be in 1..32");
    end

    state_t           state_q, state_d;
    logic [CW-1:0]    b_q, b_d;
    logic [CW-1:0]    len_q, len_d;
    logic [CW-1:0]    l_new;
    tx_word_t         word_q, word_d;
    logic             tvalid_q, tvalid_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             rdy_q, rdy_d;
    logic             len_valid;
    logic [LEN_W-1:0] hdr_len;

    ftdi_hdr_collect #(
        .LEN_W       (LEN_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_hdr (
        .clk       (clk),
        .rst       (rst),
        .arm       (rdy_q),
        .rx_tvalid (bus.rx_tvalid),
        .rx_tdata  (bus.rx_tdata),
        .len_valid (len_valid),
        .len       (hdr_len)
    );

    // Word starting at byte offset b of an L-byte transfer.
    function automatic tx_word_t make_word(input logic [CW-1:0] b, input logic [CW-1:0] l);
        tx_word_t w;
        w.tkeep = keep_from_remaining(REM_W'(l - b));
        w.tlast = (b + CW'(TX_BYTES)) >= l;
        for (int j = 0; j < 4; j++)
            w.tdata[8*j +: 8] = w.tkeep[j] ? 8'(b + CW'(j)) : 8'h00;
        return w;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HDR;
            b_q      <= '0;
            len_q    <= '0;
            word_q   <= '0;
            tvalid_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            rdy_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            b_q      <= b_d;
            len_q    <= len_d;
            word_q   <= word_d;
            tvalid_q <= tvalid_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            rdy_q    <= rdy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        b_d      = b_q;
        len_d    = len_q;
        word_d   = word_q;
        tvalid_d = tvalid_q;
        done_d   = 1'b0;
        l_new    = CW'(hdr_len);

        case (state_q)
            HDR: begin
                if (len_valid) begin
                    if (hdr_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = SEND;
                        len_d    = l_new;
                        b_d      = '0;
                        word_d   = make_word(CW'(0), l_new);
                        tvalid_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (tvalid_q && bus.tx_tready) begin
                    if (word_q.tlast) begin
                        state_d  = HDR;
                        tvalid_d = 1'b0;
                        done_d   = 1'b1;
                        word_d   = '0;
                    end else begin
                        b_d    = b_q + CW'(TX_BYTES);
                        word_d = make_word(b_q + CW'(TX_BYTES), len_q);
                    end
                end
            end
            default: ;
        endcase

        busy_d = (state_d == SEND);
        rdy_d  = (state_d == HDR);
    end

    assign bus.rx_tready = rdy_q;
    assign bus.tx_tvalid = tvalid_q;
    assign bus.tx_tdata  = word_q.tdata;
    assign bus.tx_tkeep  = word_q.tkeep;
    assign bus.tx_tlast  = word_q.tlast;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_ftdi_tx_mass_ctrl.sv
// Directed bench for ftdi_tx_mass_ctrl: header parsing, framing, backpressure, reset.
module tb_ftdi_tx_mass_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic busy, done;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ftdi_tx_mass_ctrl_if bus_if ();

    ftdi_tx_mass_ctrl #(.LEN_W(32), .TIMEOUT_CYC(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus_if),
        .busy (busy),
        .done (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_word(input string tag, input logic [31:0] d, input logic [3:0] k, input logic l);
        chk({tag, "_tvalid"}, 32'(bus_if.tx_tvalid), 32'd1);
        chk({tag, "_tdata"},  bus_if.tx_tdata, d);
        chk({tag, "_tkeep"},  32'(bus_if.tx_tkeep), 32'(k));
        chk({tag, "_tlast"},  32'(bus_if.tx_tlast), 32'(l));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rx_tready"}, 32'(bus_if.rx_tready), 32'd1);
        chk({tag, "_tx_tvalid"}, 32'(bus_if.tx_tvalid), 32'd0);
        chk({tag, "_tx_tdata"},  bus_if.tx_tdata, 32'd0);
        chk({tag, "_tx_tkeep"},  32'(bus_if.tx_tkeep), 32'd0);
        chk({tag, "_tx_tlast"},  32'(bus_if.tx_tlast), 32'd0);
        chk({tag, "_busy"},      32'(busy), 32'd0);
        chk({tag, "_done"},      32'(done), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] d);
        int n = 0;
        bus_if.rx_tvalid = 1'b1;
        bus_if.rx_tdata  = d;
        while (!bus_if.rx_tready && n < 100) begin
            tick();
            n++;
        end
        chk("rx_accept_budget", 32'(n < 100), 32'd1);
        tick();
        bus_if.rx_tvalid = 1'b0;
    endtask

    task automatic send_hdr(input logic [31:0] l);
        for (int i = 0; i < 4; i++) send_byte(l[8*i +: 8]);
    endtask

    function automatic logic [31:0] pat(input int w);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[8*j +: 8] = 8'(4*w + j);
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w;
        int cyc;
        int lasts;
        logic tr;

        rst              = 1'b1;
        bus_if.rx_tvalid = 1'b0;
        bus_if.rx_tdata  = 8'h00;
        bus_if.tx_tready = 1'b0;
        tick();
        tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        tick();

        // L=5, TX always ready
        bus_if.tx_tready = 1'b1;
        send_hdr(32'd5);
        chk_word("l5_w0", 32'h03020100, 4'hF, 1'b0);
        chk("l5_busy", 32'(busy), 32'd1);
        chk("l5_rx_tready", 32'(bus_if.rx_tready), 32'd0);
        tick();
        chk_word("l5_w1", 32'h00000004, 4'h1, 1'b1);
        chk("l5_done_early", 32'(done), 32'd0);
        tick();
        chk("l5_done", 32'(done), 32'd1);
        chk("l5_tvalid_off", 32'(bus_if.tx_tvalid), 32'd0);
        chk("l5_busy_off", 32'(busy), 32'd0);
        tick();
        chk("l5_done_pulse", 32'(done), 32'd0);

        // L=0 sends nothing; the next header follows straight away
        send_hdr(32'd0);
        chk("l0_tvalid", 32'(bus_if.tx_tvalid), 32'd0);
        chk("l0_done", 32'(done), 32'd1);
        chk("l0_rx_tready", 32'(bus_if.rx_tready), 32'd1);
        chk("l0_busy", 32'(busy), 32'd0);
        send_hdr(32'd3);
        chk_word("l3_w0", 32'h00020100, 4'h7, 1'b1);
        tick();
        chk("l3_done", 32'(done), 32'd1);

        // L=1024 with random backpressure
        send_hdr(32'd1024);
        w     = 0;
        cyc   = 0;
        lasts = 0;
        while (w < 256 && cyc < 5000) begin
            chk_word("l1024", pat(w), 4'hF, 1'(w == 255));
            if (bus_if.tx_tlast) lasts++;
            tr = 1'($urandom_range(0, 1));
            bus_if.tx_tready = tr;
            tick();
            cyc++;
            if (tr) w++;
        end
        chk("l1024_words", 32'(w), 32'd256);
        chk("l1024_done", 32'(done), 32'd1);
        chk("l1024_tvalid_off", 32'(bus_if.tx_tvalid), 32'd0);
        chk("l1024_lasts_nonzero", 32'(lasts > 0), 32'd1);
        bus_if.tx_tready = 1'b1;
        tick();

        // L=8 with RX bytes arriving during SEND
        send_hdr(32'd8);
        bus_if.tx_tready = 1'b0;
        bus_if.rx_tvalid = 1'b1;
        bus_if.rx_tdata  = 8'h02;
        for (int i = 0; i < 3; i++) begin
            chk("l8_rx_blocked", 32'(bus_if.rx_tready), 32'd0);
            chk_word("l8_w0_stall", 32'h03020100, 4'hF, 1'b0);
            tick();
        end
        bus_if.tx_tready = 1'b1;
        tick();
        chk_word("l8_w1", 32'h07060504, 4'hF, 1'b1);
        chk("l8_rx_blocked_w1", 32'(bus_if.rx_tready), 32'd0);
        tick();
        chk("l8_done", 32'(done), 32'd1);
        chk("l8_rx_rearmed", 32'(bus_if.rx_tready), 32'd1);
        tick();
        bus_if.rx_tvalid = 1'b0;
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        chk_word("l2_w0", 32'h00000100, 4'h3, 1'b1);
        tick();
        chk("l2_done", 32'(done), 32'd1);

`ifdef TX_MASS_TIMEOUT_EN
        // Partial header discarded after idling
        send_byte(8'h09);
        send_byte(8'h00);
        repeat (20) tick();
        send_hdr(32'd4);
        chk_word("to_w0", 32'h03020100, 4'hF, 1'b1);
        tick();
        chk("to_done", 32'(done), 32'd1);
`endif

        // Reset while word 3 of L=64 is on the bus
        send_hdr(32'd64);
        chk_word("rs_w0", 32'h03020100, 4'hF, 1'b0);
        tick();
        chk_word("rs_w1", 32'h07060504, 4'hF, 1'b0);
        tick();
        chk_word("rs_w2", 32'h0B0A0908, 4'hF, 1'b0);
        rst = 1'b1;
        tick();
        chk_reset_vals("midrst");
        rst = 1'b0;
        send_hdr(32'd4);
        chk_word("rs_new_w0", 32'h03020100, 4'hF, 1'b1);
        tick();
        chk("rs_new_done", 32'(done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
